// File: rtl/if_stage.sv
// Instruction fetch stage: word-indexed PC, one-cycle BOOT after reset,
// then fetch with redirect > stall > sequential priority into the IF/ID register.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_plus1,
   output logic        id_valid,
   output logic [31:0] fetch_count
);

   localparam logic [0:0] BOOT = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]  state_reg;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic [31:0] pc_plus1_reg;
   logic        valid_reg;
   logic [31:0] count_reg;
   logic [31:0] pc_inc;

   // Natural 32-bit overflow gives the required wrap from all-ones to zero.
   assign pc_inc = pc_reg + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= BOOT;
         pc_reg       <= RESET_PC;
         instr_reg    <= NOP_INSTR;
         pc_plus1_reg <= 32'd0;
         valid_reg    <= 1'b0;
         count_reg    <= 32'd0;
      end else begin
         case (state_reg)
            BOOT: begin
               state_reg <= RUN;
            end
            default: begin
               if (redirect_valid) begin
                  pc_reg       <= redirect_target;
                  instr_reg    <= NOP_INSTR;
                  pc_plus1_reg <= 32'd0;
                  valid_reg    <= 1'b0;
               end else if (!stall) begin
                  pc_reg       <= pc_inc;
                  instr_reg    <= imem_rdata;
                  pc_plus1_reg <= pc_inc;
                  valid_reg    <= 1'b1;
                  if (count_reg != 32'hFFFF_FFFF)
                     count_reg <= count_reg + 32'd1;
               end
            end
         endcase
      end
   end

   assign imem_addr   = pc_reg;
   assign id_instr    = instr_reg;
   assign id_pc_plus1 = pc_plus1_reg;
   assign id_valid    = valid_reg;
   assign fetch_count = count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: instruction memory holds imem[i] = i + 100.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus1;
   logic        id_valid;
   logic [31:0] fetch_count;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr + 32'd100;

   if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .id_instr        (id_instr),
      .id_pc_plus1     (id_pc_plus1),
      .id_valid        (id_valid),
      .fetch_count     (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
         $display("ok   %-14s got=%0d", tag, got);
      end else begin
         $display("FAIL %-14s got=%0d (0x%08h) exp=%0d (0x%08h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Check the full IF/ID picture plus PC and count in one call.
   task automatic chk_all(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pcp1, input logic vld, input logic [31:0] cnt);
      chk({tag, ".addr"},  imem_addr,   addr);
      chk({tag, ".instr"}, id_instr,    instr);
      chk({tag, ".pcp1"},  id_pc_plus1, pcp1);
      chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
      chk({tag, ".count"}, fetch_count, cnt);
   endtask

   initial begin
      rst_n           = 1'b0;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst", 0, 0, 0, 0, 0);

      rst_n = 1'b1;
      step();
      chk_all("boot", 0, 0, 0, 0, 0);
      step();
      chk_all("f0", 1, 100, 1, 1, 1);
      step();
      chk_all("f1", 2, 101, 2, 1, 2);
      step();
      chk_all("f2", 3, 102, 3, 1, 3);
      step();
      step();
      chk_all("f4", 5, 104, 5, 1, 5);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all("stall", 5, 104, 5, 1, 5);
      end
      stall = 1'b0;
      step();
      chk_all("resume", 6, 105, 6, 1, 6);
      step();
      step();
      chk_all("pc8", 8, 107, 8, 1, 8);

      redirect_valid  = 1'b1;
      redirect_target = 32'd13;
      step();
      chk_all("redir13", 13, 0, 0, 0, 8);
      redirect_valid = 1'b0;
      step();
      chk_all("after13", 14, 113, 14, 1, 9);

      redirect_valid  = 1'b1;
      redirect_target = 32'd4;
      stall           = 1'b1;
      step();
      chk_all("redir_stall", 4, 0, 0, 0, 9);
      redirect_valid = 1'b0;
      stall          = 1'b0;
      step();
      chk_all("after4", 5, 104, 5, 1, 10);

      redirect_valid  = 1'b1;
      redirect_target = 32'd5;
      step();
      chk_all("redir_same", 5, 0, 0, 0, 10);
      redirect_valid = 1'b0;
      step();
      chk_all("refetch5", 6, 105, 6, 1, 11);

      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFF;
      step();
      chk_all("redir_max", 32'hFFFF_FFFF, 0, 0, 0, 11);
      redirect_valid = 1'b0;
      step();
      chk_all("wrap", 0, 99, 0, 1, 12);
      step();
      chk_all("post_wrap", 1, 100, 1, 1, 13);
      repeat (8) step();
      chk_all("pc9", 9, 108, 9, 1, 21);

      stall = 1'b1;
      step();
      chk_all("stall9", 9, 108, 9, 1, 21);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 0, 0, 0, 0, 0);
      step();
      step();
      chk_all("rst_hold", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      stall = 1'b0;
      step();
      chk_all("reboot", 0, 0, 0, 0, 0);
      step();
      chk_all("refetch0", 1, 100, 1, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, word index loaded into the PC on reset.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0000, instruction word presented in IF/ID when a bubble is inserted.
REQ-003 Port: clk  input  1  rising-edge clock, the only clock of the block.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: imem_addr  output  32  word index of the instruction being fetched; equals the PC register, driven combinationally.
REQ-006 Port: imem_rdata  input  32  instruction word at imem_addr, combinational read, valid in the same cycle.
REQ-007 Port: stall  input  1  hazard hold request from decode.
REQ-008 Port: redirect_valid  input  1  taken branch or jump resolved downstream.
REQ-009 Port: redirect_target  input  32  word index of the next PC when redirect_valid=1.
REQ-010 Port: id_instr  output  32  IF/ID register, instruction.
REQ-011 Port: id_pc_plus1  output  32  IF/ID register, fetch PC+1; used by decode for branch/jump target math.
REQ-012 Port: id_valid  output  1  IF/ID register, 1 = real instruction, 0 = bubble.
REQ-013 Port: fetch_count  output  32  number of instructions latched into IF/ID since reset.

Function
REQ-014 The PC shall be word-indexed; sequential fetch shall add 1 modulo 2^32, with 32'hFFFF_FFFF wrapping to 0.
REQ-015 The FSM shall have two states: BOOT and RUN; reset enters BOOT.
REQ-016 BOOT: PC and IF/ID hold, id_valid=0, and stall/redirect are ignored; exactly one cycle later the FSM moves to RUN unconditionally.
REQ-017 RUN: the FSM stays in RUN until reset.
REQ-018 RUN priority per rising edge: redirect_valid, then stall, then normal fetch.
REQ-019 Redirect: PC<=redirect_target; IF/ID<={NOP_INSTR, 0, 0}, so id_valid=0 for one cycle; this applies even if stall=1.
REQ-020 Stall without redirect: PC, id_instr, id_pc_plus1, id_valid and fetch_count all hold.
REQ-021 Normal fetch: PC<=PC+1; id_instr<=imem_rdata; id_pc_plus1<=PC+1; id_valid<=1.
REQ-022 Fetch latency: an instruction at address A shall appear on id_instr one edge after imem_addr=A, given no stall or redirect.
REQ-023 fetch_count shall increment by 1 on each normal fetch, saturate at 32'hFFFF_FFFF, and never increment on BOOT, stall or redirect edges.
REQ-024 redirect_target equal to the current PC is legal: the same word is refetched after one bubble.
REQ-025 Outputs shall depend only on registered state, except imem_addr, which equals the PC register.

Reset
REQ-026 rst_n=0 shall immediately, without waiting for clk, set PC=RESET_PC, state=BOOT, id_instr=NOP_INSTR, id_pc_plus1=0, id_valid=0, fetch_count=0.
REQ-027 Reset asserted mid-stall or mid-redirect shall discard the pending operation; after release the block shall restart from BOOT at RESET_PC.
REQ-028 While rst_n=0, clock edges shall cause no state change.

Verification
REQ-029 Reset, release, imem[i]=i+100, no stall -> imem_addr=0 for two edges (BOOT); then id_instr=100,101,102 on successive edges, id_pc_plus1=1,2,3, fetch_count=1,2,3.
REQ-030 Stall held for 3 cycles while PC=5 -> imem_addr stays 5, IF/ID and fetch_count frozen; normal fetch resumes from 5 after release.
REQ-031 redirect_valid=1, target=13, with PC=8 -> next edge imem_addr=13, id_valid=0, id_instr=NOP_INSTR; following edge id_instr=imem[13], id_pc_plus1=14.
REQ-032 redirect_valid=1 and stall=1 in the same cycle, target=4 -> redirect wins: PC=4, one bubble, fetch_count unchanged.
REQ-033 Force PC=32'hFFFF_FFFF via redirect, then fetch -> imem_addr=0 next, id_pc_plus1=0.
REQ-034 Assert rst_n=0 between edges during a stall at PC=9 -> outputs reset immediately; after release, BOOT cycle, then fetch from RESET_PC.
